// File: rtl/vx_wb_arbiter.sv
// Writeback bus master: round-robin arbitration over commit ports with atomic
// sop..eop bursts, feeding a registered one-beat-per-cycle writeback bus.
module vx_wb_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int UUID_WIDTH  = 1,
  parameter int ISSUE_WIS_W = 2,
  parameter int CU_WIS_W    = 2,
  parameter int DATAW       = UUID_WIDTH + ISSUE_WIS_W + NUM_THREADS + XLEN + NR_BITS
                              + NUM_THREADS * XLEN + 2 + CU_WIS_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        wb_valid,
  output logic [DATAW-1:0]            wb_data,
  output logic [31:0]                 perf_stalls,
  output logic                        proto_err
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DATAW-1:0]      wb_data_q, wb_data_d;
  logic [31:0]           perf_stalls_q, perf_stalls_d;
  logic                  proto_err_q, proto_err_d;

  logic [NUM_INPUTS-1:0] ready_s;
  logic [IDX_W-1:0]      grant_idx_s;
  logic [IDX_W-1:0]      cand_s;
  logic                  found_s;
  logic                  hit_s;
  logic                  fire_s;
  logic                  stall_s;
  logic [DATAW-1:0]      grant_data_s;
  logic                  sop_s;
  logic                  eop_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_INPUTS - 1)) begin
      next_idx = {IDX_W{1'b0}};
    end else begin
      next_idx = idx + IDX_W'(1);
    end
  endfunction

  // Grant selection: locked port while a burst is open, else first valid from rr_ptr.
  always_comb begin
    ready_s     = {NUM_INPUTS{1'b0}};
    grant_idx_s = rr_ptr_q;
    cand_s      = rr_ptr_q;
    found_s     = 1'b0;
    hit_s       = 1'b0;
    if (!reset) begin
      ready_s = {NUM_INPUTS{1'b0}};
    end else if (state_q == ST_LOCKED) begin
      grant_idx_s          = lock_idx_q;
      ready_s[lock_idx_q]  = 1'b1;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        hit_s       = ~found_s & in_valid[cand_s];
        grant_idx_s = hit_s ? cand_s : grant_idx_s;
        found_s     = found_s | hit_s;
        cand_s      = next_idx(cand_s);
      end
      ready_s[grant_idx_s] = found_s;
    end
  end

  assign fire_s       = |(in_valid & ready_s);
  assign stall_s      = |(in_valid & ~ready_s);
  assign grant_data_s = in_data[grant_idx_s*DATAW +: DATAW];
  assign sop_s        = grant_data_s[CU_WIS_W+1];
  assign eop_s        = grant_data_s[CU_WIS_W];

  // Next-state: burst lock tracking, pointer update, protocol checks, output beat.
  always_comb begin
    state_d       = state_q;
    lock_idx_d    = lock_idx_q;
    rr_ptr_d      = rr_ptr_q;
    proto_err_d   = proto_err_q;
    wb_valid_d    = fire_s;
    wb_data_d     = fire_s ? grant_data_s : wb_data_q;
    perf_stalls_d = (stall_s && (perf_stalls_q != 32'hFFFF_FFFF)) ? perf_stalls_q + 32'd1
                                                                   : perf_stalls_q;
    if (fire_s) begin
      case (state_q)
        ST_IDLE: begin
          rr_ptr_d    = next_idx(grant_idx_s);
          proto_err_d = proto_err_q | ~sop_s;
          if (sop_s && !eop_s) begin
            state_d    = ST_LOCKED;
            lock_idx_d = grant_idx_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          // A stray sop inside a burst is flagged but its eop still decides the lock.
          proto_err_d = proto_err_q | sop_s;
          if (eop_s) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_idx(lock_idx_q);
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      lock_idx_q    <= {IDX_W{1'b0}};
      rr_ptr_q      <= {IDX_W{1'b0}};
      wb_valid_q    <= 1'b0;
      wb_data_q     <= {DATAW{1'b0}};
      perf_stalls_q <= 32'd0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_idx_q    <= lock_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      perf_stalls_q <= perf_stalls_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign in_ready    = ready_s;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign perf_stalls = perf_stalls_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Directed bench for vx_wb_arbiter: grant order, burst locking, gaps, protocol
// errors, streaming and stall-counter saturation against hand-derived values.
module tb_vx_wb_arbiter;

  localparam int N     = 4;
  localparam int UUIDW = 8;
  localparam int DATAW = UUIDW + 2 + 4 + 32 + 6 + 4 * 32 + 2 + 2;

  logic                  clk;
  logic                  reset;
  logic [N-1:0]          in_valid;
  logic [N*DATAW-1:0]    in_data;
  logic [N-1:0]          in_ready;
  logic                  wb_valid;
  logic [DATAW-1:0]      wb_data;
  logic [31:0]           perf_stalls;
  logic                  proto_err;

  int                    n_cmp;
  int                    n_err;
  int                    step_no;
  logic [DATAW-1:0]      pkt [N];
  logic                  exp_wbv;
  logic [DATAW-1:0]      exp_wbd;
  logic [31:0]           exp_stalls;
  logic                  exp_perr;
  logic [31:0]           base_stalls;

  vx_wb_arbiter #(
    .NUM_INPUTS (N),
    .NUM_THREADS(4),
    .XLEN       (32),
    .NR_BITS    (6),
    .UUID_WIDTH (UUIDW),
    .ISSUE_WIS_W(2),
    .CU_WIS_W   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .perf_stalls(perf_stalls),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet {uuid, wis, tmask, PC, rd, data, sop, eop, cu_id}
  function automatic logic [DATAW-1:0] mk(input int id, input logic s, input logic e);
    logic [31:0] idv;
    idv = id;
    mk  = {idv[7:0], 2'b10, 4'hF, 32'h8000_0000 + idv, idv[5:0],
           {4{idv ^ 32'h5A5A_0000}}, s, e, 2'b01};
  endfunction

  task automatic load_data();
    for (int p = 0; p < N; p++) in_data[p*DATAW +: DATAW] = pkt[p];
  endtask

  // One cycle: check last cycle's outputs at negedge, drive v, check ready, update model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] exp_rdy);
    @(negedge clk);
    step_no++;
    check_eq($sformatf("wb_valid@%0d", step_no), {255'd0, wb_valid}, {255'd0, exp_wbv});
    if (exp_wbv) check_eq($sformatf("wb_data@%0d", step_no), {72'd0, wb_data}, {72'd0, exp_wbd});
    check_eq($sformatf("perf_stalls@%0d", step_no), {224'd0, perf_stalls}, {224'd0, exp_stalls});
    check_eq($sformatf("proto_err@%0d", step_no), {255'd0, proto_err}, {255'd0, exp_perr});
    in_valid = v;
    load_data();
    #1;
    check_eq($sformatf("in_ready@%0d", step_no), {252'd0, in_ready}, {252'd0, exp_rdy});
    exp_wbv = |(v & exp_rdy);
    for (int p = 0; p < N; p++) if (v[p] & exp_rdy[p]) exp_wbd = pkt[p];
    if (|(v & ~exp_rdy) && exp_stalls != 32'hFFFF_FFFF) exp_stalls = exp_stalls + 32'd1;
  endtask

  task automatic reset_model();
    exp_wbv    = 1'b0;
    exp_wbd    = '0;
    exp_stalls = 32'd0;
    exp_perr   = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    step_no = 0;
    reset_model();

    // Power-on reset with all ports requesting
    reset    = 1'b0;
    in_valid = 4'b1111;
    for (int p = 0; p < N; p++) pkt[p] = mk(16 + p, 1'b1, 1'b1);
    load_data();
    #12;
    check_eq("rst_in_ready", {252'd0, in_ready}, 256'd0);
    check_eq("rst_wb_valid", {255'd0, wb_valid}, 256'd0);
    check_eq("rst_wb_data", {72'd0, wb_data}, 256'd0);
    check_eq("rst_stalls", {224'd0, perf_stalls}, 256'd0);
    check_eq("rst_proto_err", {255'd0, proto_err}, 256'd0);
    in_valid = 4'b0000;
    @(negedge clk);
    reset = 1'b1;

    // Burst lock: move rr_ptr to 2, then port 2 bursts while 0,1,3 wait
    for (int p = 0; p < N; p++) pkt[p] = mk(32 + p, 1'b1, 1'b1);
    step(4'b0010, 4'b0010);
    pkt[2] = mk(40, 1'b1, 1'b0);
    step(4'b1111, 4'b0100);
    pkt[2] = mk(41, 1'b0, 1'b0);
    step(4'b1111, 4'b0100);
    pkt[2] = mk(42, 1'b0, 1'b1);
    step(4'b1111, 4'b0100);
    step(4'b1011, 4'b1000);
    step(4'b0011, 4'b0001);
    step(4'b0000, 4'b0000);

    // Burst gap on port 1 while port 0 waits
    pkt[0] = mk(48, 1'b1, 1'b1);
    pkt[1] = mk(49, 1'b1, 1'b0);
    step(4'b0011, 4'b0010);
    step(4'b0001, 4'b0010);
    step(4'b0001, 4'b0010);
    pkt[1] = mk(50, 1'b0, 1'b0);
    step(4'b0011, 4'b0010);
    pkt[1] = mk(51, 1'b0, 1'b1);
    step(4'b0011, 4'b0010);
    step(4'b0001, 4'b0001);
    step(4'b0000, 4'b0000);

    // Reset asserted mid-burst on port 2
    pkt[2] = mk(80, 1'b1, 1'b0);
    step(4'b0100, 4'b0100);
    pkt[0] = mk(81, 1'b1, 1'b1);
    pkt[2] = mk(82, 1'b0, 1'b0);
    step(4'b0101, 4'b0100);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midrst_in_ready", {252'd0, in_ready}, 256'd0);
    check_eq("midrst_wb_valid", {255'd0, wb_valid}, 256'd0);
    check_eq("midrst_wb_data", {72'd0, wb_data}, 256'd0);
    check_eq("midrst_stalls", {224'd0, perf_stalls}, 256'd0);
    check_eq("midrst_proto_err", {255'd0, proto_err}, 256'd0);
    in_valid = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    reset_model();

    // All ports valid, single beats: grants 0,1,2,3,0
    for (int p = 0; p < N; p++) pkt[p] = mk(96 + p, 1'b1, 1'b1);
    step(4'b1111, 4'b0001);
    step(4'b1111, 4'b0010);
    step(4'b1111, 4'b0100);
    step(4'b1111, 4'b1000);
    step(4'b1111, 4'b0001);
    step(4'b0000, 4'b0000);

    // sop=0 while idle: forwarded, sticky error
    pkt[0] = mk(112, 1'b0, 1'b1);
    step(4'b0001, 4'b0001);
    exp_perr = 1'b1;
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Separate run: sop=1 while locked
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    reset_model();
    pkt[0] = mk(128, 1'b1, 1'b0);
    step(4'b0001, 4'b0001);
    pkt[0] = mk(129, 1'b1, 1'b0);
    step(4'b0001, 4'b0001);
    exp_perr = 1'b1;
    pkt[0] = mk(130, 1'b0, 1'b1);
    pkt[1] = mk(131, 1'b1, 1'b1);
    step(4'b0011, 4'b0001);
    step(4'b0010, 4'b0010);
    step(4'b0000, 4'b0000);

    // Streaming 100 single beats from port 0
    base_stalls = exp_stalls;
    for (int i = 0; i < 100; i++) begin
      pkt[0] = mk(i, 1'b1, 1'b1);
      step(4'b0001, 4'b0001);
    end
    step(4'b0000, 4'b0000);
    check_eq("stream_stalls", {224'd0, perf_stalls}, {224'd0, base_stalls});

    // Stall counter saturation
    @(negedge clk);
    force dut.perf_stalls_q = 32'hFFFF_FFFE;
    #1;
    release dut.perf_stalls_q;
    exp_stalls = 32'hFFFF_FFFE;
    exp_wbv    = 1'b0;
    pkt[0] = mk(144, 1'b1, 1'b1);
    pkt[1] = mk(145, 1'b1, 1'b1);
    step(4'b0011, 4'b0010);
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0010);
    step(4'b0000, 4'b0000);
    check_eq("sat_stalls", {224'd0, perf_stalls}, {224'd0, 32'hFFFF_FFFF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
